mem_bus_responder: RTL and testbench

- Memory-side responder for the cache/bus protocol that the fetch cache drives as initiator.
- Accepts line requests on the request channel and returns 8-beat cache-line reads on the response channel, echoing the request tag.
- Also accepts 8-beat line writes.
- Used as the memory model behind the I-cache/D-cache, and as the DUT-side counterpart for bus-protocol benches.

---
 rtl/mem_bus_responder_pkg.sv | 25 ++
 rtl/mem_bus_responder_if.sv | 26 ++
 rtl/mem_bus_responder_mem_array.sv | 33 +++
 rtl/mem_bus_responder.sv | 142 ++++++++++++++
 tb/tb_mem_bus_responder.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_responder_pkg.sv
// Shared types and constants for the cache-line memory responder.
package mem_bus_responder_pkg;

    localparam int BUS_DATA_WIDTH_DEF = 64;
    localparam int BUS_TAG_WIDTH_DEF  = 13;
    localparam int WRITE_FLAG_BIT     = BUS_TAG_WIDTH_DEF - 1;
    localparam int LINE_BYTES         = 64;
    localparam int LINE_BEATS         = 8;
    localparam int LINE_OFF_BITS      = $clog2(LINE_BYTES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WDATA = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    // Align a byte address down to the start of its cache line.
    function automatic logic [BUS_DATA_WIDTH_DEF-1:0] line_base(
        input logic [BUS_DATA_WIDTH_DEF-1:0] addr
    );
        return {addr[BUS_DATA_WIDTH_DEF-1:LINE_OFF_BITS], {LINE_OFF_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/mem_bus_responder_if.sv
// Request/response bus between a cache (initiator) and the memory responder.
interface mem_bus_responder_if #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13
) ();

    logic                      bus_reqcyc;
    logic                      bus_reqack;
    logic [BUS_DATA_WIDTH-1:0] bus_req;
    logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
    logic                      bus_respcyc;
    logic                      bus_respack;
    logic [BUS_DATA_WIDTH-1:0] bus_resp;
    logic [BUS_TAG_WIDTH-1:0]  bus_resptag;

    modport master (
        output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        input  bus_reqack, bus_respcyc, bus_resp, bus_resptag
    );

    modport slave (
        input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        output bus_reqack, bus_respcyc, bus_resp, bus_resptag
    );

endinterface

// File: rtl/mem_bus_responder_mem_array.sv
// Backing store: two synchronous write ports (port 0 wins on a same-word
// collision) and one asynchronous read port. Contents survive reset.
module mem_array #(
    parameter int WORDS  = 4096,
    parameter int DW     = 64,
    localparam int AW    = $clog2(WORDS)
) (
    input  logic          clk_i,
    input  logic          we0_i,
    input  logic [AW-1:0] waddr0_i,
    input  logic [DW-1:0] wdata0_i,
    input  logic          we1_i,
    input  logic [AW-1:0] waddr1_i,
    input  logic [DW-1:0] wdata1_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [WORDS];

    // Write both ports; port 1 is suppressed when port 0 targets the same word.
    always_ff @(posedge clk_i) begin
        if (we0_i) begin
            mem_q[waddr0_i] <= wdata0_i;
        end
        if (we1_i && !(we0_i && (waddr0_i == waddr1_i))) begin
            mem_q[waddr1_i] <= wdata1_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder: serves 8-beat line reads after a fixed latency and
// absorbs 8-beat line writes, one outstanding transaction at a time.
module mem_bus_responder
    import mem_bus_responder_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = BUS_DATA_WIDTH_DEF,
    parameter int BUS_TAG_WIDTH  = BUS_TAG_WIDTH_DEF,
    parameter int MEM_WORDS      = 4096,
    parameter int RESP_LATENCY   = 4,
    parameter int BEATS          = LINE_BEATS,
    localparam int ADDR_W        = $clog2(MEM_WORDS)
) (
    input  logic                      clk,
    input  logic                      reset,
    mem_bus_responder_if.slave        bus,
    input  logic                      init_we,
    input  logic [ADDR_W-1:0]         init_addr,
    input  logic [BUS_DATA_WIDTH-1:0] init_data,
    output logic                      busy
);

    localparam int WR_BIT   = BUS_TAG_WIDTH - 1;
    localparam int BEAT_W   = $clog2(BEATS);
    localparam int CNT_W    = $clog2(RESP_LATENCY + 1);
    localparam int WORD_OFF = $clog2(BUS_DATA_WIDTH / 8);

    state_e                   state_q, state_d;
    logic [BEAT_W-1:0]        beat_q, beat_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [BUS_TAG_WIDTH-1:0] tag_q, tag_d;
    logic [ADDR_W-1:0]        base_q, base_d;

    logic                      accepting;
    logic                      resp_on;
    logic                      req_fire;
    logic                      bus_we;
    logic [ADDR_W-1:0]         req_word;
    logic [ADDR_W-1:0]         beat_addr;
    logic [BUS_DATA_WIDTH-1:0] rdata;

    // Reset gates the handshake outputs so they drop without waiting for a clock.
    assign accepting = !reset && ((state_q == IDLE) || (state_q == WDATA));
    assign resp_on   = !reset && (state_q == RESP);
    assign req_fire  = bus.bus_reqcyc && accepting;
    assign bus_we    = req_fire && (state_q == WDATA);

    // Word index of the line base; wraps modulo MEM_WORDS by truncation.
    assign req_word  = ADDR_W'(line_base(bus.bus_req) >> WORD_OFF);
    assign beat_addr = base_q + ADDR_W'(beat_q);

    assign bus.bus_reqack  = req_fire;
    assign bus.bus_respcyc = resp_on;
    assign bus.bus_resp    = resp_on ? rdata : '0;
    assign bus.bus_resptag = resp_on ? tag_q : '0;
    assign busy            = (state_q != IDLE);

    mem_array #(
        .WORDS (MEM_WORDS),
        .DW    (BUS_DATA_WIDTH)
    ) u_mem (
        .clk_i    (clk),
        .we0_i    (bus_we),
        .waddr0_i (beat_addr),
        .wdata0_i (bus.bus_req),
        .we1_i    (init_we),
        .waddr1_i (init_addr),
        .wdata1_i (init_data),
        .raddr_i  (beat_addr),
        .rdata_o  (rdata)
    );

    // Next-state logic: request decode, write beat counting, latency countdown, read beats.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        tag_d   = tag_q;
        base_d  = base_q;
        case (state_q)
            IDLE: begin
                if (req_fire) begin
                    tag_d  = bus.bus_reqtag;
                    base_d = req_word;
                    beat_d = '0;
                    if (bus.bus_reqtag[WR_BIT]) begin
                        state_d = WDATA;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(RESP_LATENCY - 1);
                    end
                end
            end
            WDATA: begin
                if (req_fire) begin
                    if (beat_q == BEAT_W'(BEATS - 1)) begin
                        state_d = IDLE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    beat_d  = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (bus.bus_respack) begin
                    if (beat_q == BEAT_W'(BEATS - 1)) begin
                        state_d = IDLE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and latched request registers; reset abandons any transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            cnt_q   <= '0;
            tag_q   <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
            base_q  <= base_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench for mem_bus_responder with a word-array reference model.
module tb_mem_bus_responder;
    import mem_bus_responder_pkg::*;

    localparam int DW        = 64;
    localparam int TW        = 13;
    localparam int MEM_WORDS = 4096;
    localparam int LAT       = 4;
    localparam int NB        = 8;
    localparam int AW        = $clog2(MEM_WORDS);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          init_we = 1'b0;
    logic [AW-1:0] init_addr = '0;
    logic [DW-1:0] init_data = '0;
    logic          busy;

    mem_bus_responder_if #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW)) bus_if ();

    mem_bus_responder #(
        .BUS_DATA_WIDTH (DW),
        .BUS_TAG_WIDTH  (TW),
        .MEM_WORDS      (MEM_WORDS),
        .RESP_LATENCY   (LAT),
        .BEATS          (NB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_if),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_data (init_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [DW-1:0] mdl [MEM_WORDS];

    // Beat k of the line containing byte address addr, from the model.
    function automatic logic [DW-1:0] exp_beat(input logic [DW-1:0] addr, input int k);
        longint unsigned line_no = longint'(addr / LINE_BYTES);
        longint unsigned w = (line_no * NB + longint'(k)) % MEM_WORDS;
        return mdl[int'(w)];
    endfunction

    function automatic logic [TW-1:0] wr_tag(input logic [TW-1:0] t);
        logic [TW-1:0] flag;
        flag = '0;
        flag[WRITE_FLAG_BIT] = 1'b1;
        return t | flag;
    endfunction

    task automatic preload(input int w, input logic [DW-1:0] d);
        @(posedge clk); #1;
        init_we = 1'b1; init_addr = AW'(w); init_data = d;
        mdl[w] = d;
        @(posedge clk); #1;
        init_we = 1'b0;
    endtask

    // Present a request and hold it until accepted; returns 1ns after the accept edge.
    task automatic issue_req(input logic [DW-1:0] addr, input logic [TW-1:0] tag, output int waited);
        @(posedge clk); #1;
        bus_if.bus_req = addr; bus_if.bus_reqtag = tag; bus_if.bus_reqcyc = 1'b1;
        #1;
        waited = 0;
        while (bus_if.bus_reqack !== 1'b1 && waited < 40) begin
            @(posedge clk); #2; waited++;
        end
        n_vec++;
        if (bus_if.bus_reqack !== 1'b1) begin
            n_err++;
            $display("FAIL req_accept tag=%h: reqack=%b after %0d cycles, required 1", tag, bus_if.bus_reqack, waited);
        end
        @(posedge clk); #1;
        bus_if.bus_reqcyc = 1'b0;
    endtask

    // Called 1ns after a read accept edge: checks latency, every beat and line end.
    task automatic collect_line(input logic [DW-1:0] addr, input logic [TW-1:0] tag, input bit rand_ack);
        int lat, k, cyc;
        bit ack;
        #1;
        lat = 1;
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_wait: busy=%b required 1", busy);
        end
        while (bus_if.bus_respcyc !== 1'b1 && lat < 40) begin
            @(posedge clk); #2; lat++;
        end
        n_vec++;
        if (lat != LAT + 1) begin
            n_err++;
            $display("FAIL first_beat_latency tag=%h: %0d cycles, required %0d", tag, lat, LAT + 1);
        end
        k = 0; cyc = 0;
        while (k < NB && cyc < 400) begin
            ack = rand_ack ? 1'($urandom_range(0, 1)) : 1'b1;
            bus_if.bus_respack = ack;
            n_vec++;
            if (bus_if.bus_respcyc !== 1'b1 || bus_if.bus_resp !== exp_beat(addr, k) || bus_if.bus_resptag !== tag) begin
                n_err++;
                $display("FAIL read_beat addr=%h k=%0d: respcyc=%b resp=%h tag=%h, required 1 %h %h",
                         addr, k, bus_if.bus_respcyc, bus_if.bus_resp, bus_if.bus_resptag, exp_beat(addr, k), tag);
            end
            if (ack) k++;
            @(posedge clk); #2; cyc++;
        end
        bus_if.bus_respack = 1'b0;
        n_vec++;
        if (bus_if.bus_respcyc !== 1'b0 || busy !== 1'b0 || bus_if.bus_resp !== '0 || bus_if.bus_resptag !== '0) begin
            n_err++;
            $display("FAIL line_end tag=%h: respcyc=%b busy=%b resp=%h tag=%h, required all 0",
                     tag, bus_if.bus_respcyc, busy, bus_if.bus_resp, bus_if.bus_resptag);
        end
    endtask

    task automatic test_reset();
        bus_if.bus_reqcyc = 1'b1; bus_if.bus_req = '0; bus_if.bus_reqtag = '0; bus_if.bus_respack = 1'b0;
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        n_vec++;
        if (bus_if.bus_reqack !== 1'b0 || bus_if.bus_respcyc !== 1'b0 || bus_if.bus_resp !== '0 ||
            bus_if.bus_resptag !== '0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: reqack=%b respcyc=%b resp=%h tag=%h busy=%b, required all 0",
                     bus_if.bus_reqack, bus_if.bus_respcyc, bus_if.bus_resp, bus_if.bus_resptag, busy);
        end
        bus_if.bus_reqcyc = 1'b0;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_read_basic();
        int w;
        issue_req(64'h0, 13'h005, w);
        n_vec++;
        if (w != 0) begin
            n_err++;
            $display("FAIL idle_ack_delay: %0d cycles, required 0", w);
        end
        collect_line(64'h0, 13'h005, 1'b0);
    endtask

    task automatic test_read_stall();
        int w;
        issue_req(64'h0, 13'h005, w);
        collect_line(64'h0, 13'h005, 1'b1);
    endtask

    // Line write with random request gaps and a colliding preload on beat 2.
    task automatic test_write(input logic [DW-1:0] addr, input bit fixed_data);
        int w, gaps, word;
        logic [DW-1:0] d;
        issue_req(addr, wr_tag(TW'($urandom_range(0, 255))), w);
        for (int b = 0; b < NB; b++) begin
            gaps = $urandom_range(0, 2);
            bus_if.bus_req = {$urandom, $urandom};
            repeat (gaps) begin
                #1;
                n_vec++;
                if (bus_if.bus_reqack !== 1'b0 || bus_if.bus_respcyc !== 1'b0) begin
                    n_err++;
                    $display("FAIL write_gap b=%0d: reqack=%b respcyc=%b, required 0 0", b, bus_if.bus_reqack, bus_if.bus_respcyc);
                end
                @(posedge clk); #1;
            end
            d = fixed_data ? DW'(64'hA0 + b) : {$urandom, $urandom};
            word = int'(((addr / LINE_BYTES) * NB + DW'(b)) % MEM_WORDS);
            bus_if.bus_reqcyc = 1'b1; bus_if.bus_req = d;
            if (b == 2) begin
                init_we = 1'b1; init_addr = AW'(word); init_data = 64'hDEAD_BEEF_0000_0000;
            end
            #1;
            n_vec++;
            if (bus_if.bus_reqack !== 1'b1 || bus_if.bus_respcyc !== 1'b0 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL write_beat b=%0d: reqack=%b respcyc=%b busy=%b, required 1 0 1",
                         b, bus_if.bus_reqack, bus_if.bus_respcyc, busy);
            end
            mdl[word] = d;
            @(posedge clk); #1;
            bus_if.bus_reqcyc = 1'b0; init_we = 1'b0;
        end
        #1;
        n_vec++;
        if (busy !== 1'b0 || bus_if.bus_respcyc !== 1'b0) begin
            n_err++;
            $display("FAIL write_end: busy=%b respcyc=%b, required 0 0", busy, bus_if.bus_respcyc);
        end
        issue_req(addr, 13'h00A, w);
        collect_line(addr, 13'h00A, 1'b1);
    endtask

    task automatic test_unaligned_wrap();
        int w;
        issue_req(64'h7C, 13'h011, w);
        collect_line(64'h40, 13'h011, 1'b1);
        issue_req(64'(MEM_WORDS * 8 + 'h40), 13'h012, w);
        collect_line(64'h40, 13'h012, 1'b0);
    endtask

    task automatic test_reset_mid();
        int w, cyc;
        issue_req(64'h0, 13'h007, w);
        #1;
        cyc = 0;
        while (bus_if.bus_respcyc !== 1'b1 && cyc < 40) begin
            @(posedge clk); #2; cyc++;
        end
        bus_if.bus_respack = 1'b1;
        repeat (3) begin @(posedge clk); #2; end
        n_vec++;
        if (bus_if.bus_respcyc !== 1'b1 || bus_if.bus_resp !== exp_beat(64'h0, 3)) begin
            n_err++;
            $display("FAIL rst_mid_beat3: respcyc=%b resp=%h, required 1 %h", bus_if.bus_respcyc, bus_if.bus_resp, exp_beat(64'h0, 3));
        end
        bus_if.bus_reqcyc = 1'b1; reset = 1'b1;
        #1;
        n_vec++;
        if (bus_if.bus_respcyc !== 1'b0 || bus_if.bus_reqack !== 1'b0 || bus_if.bus_resp !== '0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_async: respcyc=%b reqack=%b resp=%h busy=%b, required all 0",
                     bus_if.bus_respcyc, bus_if.bus_reqack, bus_if.bus_resp, busy);
        end
        @(posedge clk);
        @(negedge clk);
        bus_if.bus_reqcyc = 1'b0; bus_if.bus_respack = 1'b0; reset = 1'b0;
        issue_req(64'h0, 13'h008, w);
        n_vec++;
        if (w != 0) begin
            n_err++;
            $display("FAIL rst_mid_idle: ack after %0d cycles, required 0", w);
        end
        collect_line(64'h0, 13'h008, 1'b1);
    endtask

    task automatic test_back_to_back();
        int w, k, cyc;
        issue_req(64'h0, 13'h001, w);
        bus_if.bus_req = 64'h40; bus_if.bus_reqtag = 13'h002; bus_if.bus_reqcyc = 1'b1; bus_if.bus_respack = 1'b1;
        #1;
        k = 0; cyc = 0;
        while (k < NB && cyc < 60) begin
            n_vec++;
            if (bus_if.bus_reqack !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_early_ack cyc=%0d: reqack=%b required 0", cyc, bus_if.bus_reqack);
            end
            if (bus_if.bus_respcyc === 1'b1) begin
                n_vec++;
                if (bus_if.bus_resp !== exp_beat(64'h0, k) || bus_if.bus_resptag !== 13'h001) begin
                    n_err++;
                    $display("FAIL b2b_first k=%0d: resp=%h tag=%h, required %h 001",
                             k, bus_if.bus_resp, bus_if.bus_resptag, exp_beat(64'h0, k));
                end
                k++;
            end
            @(posedge clk); #2; cyc++;
        end
        n_vec++;
        if (bus_if.bus_reqack !== 1'b1 || bus_if.bus_respcyc !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_second_ack: reqack=%b respcyc=%b, required 1 0", bus_if.bus_reqack, bus_if.bus_respcyc);
        end
        @(posedge clk); #1;
        bus_if.bus_reqcyc = 1'b0;
        collect_line(64'h40, 13'h002, 1'b0);
    endtask

    task automatic test_random_reads();
        int w;
        logic [DW-1:0] a;
        logic [TW-1:0] t;
        for (int i = 0; i < 6; i++) begin
            a = DW'($urandom_range(0, 4 * LINE_BYTES - 1));
            t = TW'($urandom_range(0, (1 << WRITE_FLAG_BIT) - 1));
            issue_req(a, t, w);
            collect_line(a, t, 1'b1);
        end
    endtask

    initial begin
        bus_if.bus_reqcyc = 1'b0; bus_if.bus_req = '0; bus_if.bus_reqtag = '0; bus_if.bus_respack = 1'b0;
        for (int i = 0; i < MEM_WORDS; i++) mdl[i] = '0;
        test_reset();
        for (int i = 0; i < 32; i++) begin
            preload(i, (i < NB) ? DW'(64'h1000 + i) : {$urandom, $urandom});
        end
        test_read_basic();
        test_read_stall();
        test_write(64'h40, 1'b1);
        test_write(64'h80, 1'b0);
        test_unaligned_wrap();
        test_reset_mid();
        test_back_to_back();
        test_random_reads();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
